// File: rtl/pam8_upsampler.sv
// pam8_upsampler: 8-PAM symbol FIFO, Gray-to-level map and zero-stuffing
// upsampler that feeds the RRC pulse-shaping FIR one sample per clock.
// Optional build macro PAM8_PRBS_EN adds an internal PRBS-9 symbol source.
module pam8_upsampler #(
    parameter int UPS        = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [2:0]                      sym_in,
    input  logic                            sym_valid,
    output logic                            sym_ready,
    input  logic                            en,
    input  logic                            clr_flags,
    input  logic                            prbs_sel,
    output logic signed [3:0]               data,
    output logic [$clog2(UPS)-1:0]          phase,
    output logic                            underflow,
    output logic [$clog2(FIFO_DEPTH):0]     level
);

    localparam int PW = $clog2(UPS);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [2:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         cnt;
    logic [PW-1:0]       phase_p0;
    logic signed [3:0]   data_p1;
    logic                uflow_q;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                slot_p0;
    logic [2:0]          wr_sym;

    // Gray-coded symbol to odd signed level; range fits 4 bits without saturation
    function automatic logic signed [3:0] gray_to_level(input logic [2:0] g);
        case (g)
            3'b000:  return -4'sd7;
            3'b001:  return -4'sd5;
            3'b011:  return -4'sd3;
            3'b010:  return -4'sd1;
            3'b110:  return  4'sd1;
            3'b111:  return  4'sd3;
            3'b101:  return  4'sd5;
            default: return  4'sd7;
        endcase
    endfunction

    assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
    assign empty   = (cnt == '0);
    assign slot_p0 = en && (phase_p0 == '0);
    assign pop     = slot_p0 && !empty;

`ifdef PAM8_PRBS_EN
    logic [8:0] prbs_q;
    logic       prbs_push;

    // Advance the x^9+x^5+1 sequence by three bits (one symbol)
    function automatic logic [8:0] prbs_step3(input logic [8:0] s);
        logic [8:0] r;
        r = s;
        for (int i = 0; i < 3; i++) r = {r[7:0], r[8] ^ r[4]};
        return r;
    endfunction

    assign prbs_push = prbs_sel && !full;
    assign sym_ready = !full && !prbs_sel;
    assign push      = prbs_push || (sym_valid && sym_ready);
    assign wr_sym    = prbs_sel ? prbs_q[2:0] : sym_in;

    // PRBS state: restarts from the all-ones seed, steps once per generated symbol
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            prbs_q <= 9'h1FF;
        else if (prbs_push) prbs_q <= prbs_step3(prbs_q);
    end
`else
    logic unused_prbs_sel;
    assign unused_prbs_sel = prbs_sel;
    assign sym_ready       = !full;
    assign push            = sym_valid && sym_ready;
    assign wr_sym          = sym_in;
`endif

    // FIFO storage: contents need no reset, pointers decide validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_sym;
    end

    // FIFO pointers and occupancy; a push and pop together leave the count alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Stage p0 -> p1: phase counter, level/zero sample register, sticky underflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_p0 <= '0;
            data_p1  <= '0;
            uflow_q  <= 1'b0;
        end else begin
            if (!en)                              phase_p0 <= '0;
            else if (phase_p0 == PW'(UPS - 1))    phase_p0 <= '0;
            else                                  phase_p0 <= phase_p0 + 1'b1;

            data_p1 <= pop ? gray_to_level(mem[rd_ptr]) : 4'sd0;

            if (slot_p0 && empty) uflow_q <= 1'b1;
            else if (clr_flags)   uflow_q <= 1'b0;
        end
    end

    assign data      = data_p1;
    assign phase     = phase_p0;
    assign underflow = uflow_q;
    assign level     = cnt;

endmodule

// File: tb/tb_pam8_upsampler.sv
// tb_pam8_upsampler: directed self-checking bench for pam8_upsampler.
module tb_pam8_upsampler;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        sym_in;
    logic              sym_valid;
    logic              sym_ready;
    logic              en;
    logic              clr_flags;
    logic              prbs_sel;
    logic signed [3:0] data;
    logic [1:0]        phase;
    logic              underflow;
    logic [3:0]        level;

    int n_tests = 0;
    int n_fail  = 0;

    // Gray map written out by hand, indexed by the binary code
    int lev [8] = '{-7, -5, -1, -3, 7, 5, 1, 3};

    pam8_upsampler #(.UPS(4), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .en        (en),
        .clr_flags (clr_flags),
        .prbs_sel  (prbs_sel),
        .data      (data),
        .phase     (phase),
        .underflow (underflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [2:0] s);
        sym_in    = s;
        sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        logic [2:0] code [9];
        int         exp_v;

        rst = 1'b1; sym_in = '0; sym_valid = 1'b0; en = 1'b0;
        clr_flags = 1'b0; prbs_sel = 1'b0;
        do_reset();
        check("rst_data",  int'(data), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_level", int'(level), 0);
        check("rst_uflow", int'(underflow), 0);
        check("rst_ready", int'(sym_ready), 1);

        // Two symbols, then stream: -7,0,0,0,+7,0,0,0
        push(3'b000);
        push(3'b100);
        check("t2_level", int'(level), 2);
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_v = (k == 0) ? -7 : (k == 4) ? 7 : 0;
            check($sformatf("t2_data%0d", k), int'(data), exp_v);
            check($sformatf("t2_phase%0d", k), int'(phase), (k + 1) % 4);
        end
        check("t2_uflow", int'(underflow), 0);

        // Empty FIFO at a level slot sets underflow
        step();
        check("t4_data", int'(data), 0);
        check("t4_uflow_set", int'(underflow), 1);
        step(); step(); step();
        clr_flags = 1'b1;
        step();
        check("t4_set_wins", int'(underflow), 1);
        en = 1'b0;
        step();
        check("t4_clr", int'(underflow), 0);
        clr_flags = 1'b0;

        // All eight codes in binary order
        for (int i = 0; i < 8; i++) push(3'(i));
        check("t3_level", int'(level), 8);
        en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            exp_v = (k % 4 == 0) ? lev[k / 4] : 0;
            check($sformatf("t3_data%0d", k), int'(data), exp_v);
        end
        check("t3_level_end", int'(level), 0);

        // Asynchronous reset in the middle of a stream
        step();
        check("t1_uflow_pre", int'(underflow), 1);
        en = 1'b0;
        step();
        push(3'b101);
        push(3'b011);
        en = 1'b1;
        step();
        check("t1_data_pre", int'(data), 5);
        #1 rst = 1'b1;
        #1;
        check("t1_data",  int'(data), 0);
        check("t1_phase", int'(phase), 0);
        check("t1_level", int'(level), 0);
        check("t1_uflow", int'(underflow), 0);
        check("t1_ready", int'(sym_ready), 1);
        en = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Fill to full, one rejected push, then drain with a push+pop slot
        code = '{3'd0, 3'd3, 3'd6, 3'd1, 3'd4, 3'd7, 3'd2, 3'd5, 3'b100};
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_ready%0d", i), int'(sym_ready), 1);
            push(code[i]);
        end
        check("t5_ready_full", int'(sym_ready), 0);
        check("t5_level_full", int'(level), 8);
        push(3'b110);
        check("t5_level_rej", int'(level), 8);
        en = 1'b1;
        for (int s = 0; s < 9; s++) begin
            for (int j = 0; j < 4; j++) begin
                if (s == 1 && j == 0) begin
                    sym_in = code[8]; sym_valid = 1'b1;
                end
                step();
                sym_valid = 1'b0;
                exp_v = (j == 0) ? lev[code[s]] : 0;
                check($sformatf("t5_data%0d_%0d", s, j), int'(data), exp_v);
                if (s == 0 && j == 0) begin
                    check("t5_level_pop", int'(level), 7);
                    check("t5_ready_pop", int'(sym_ready), 1);
                end
                if (s == 1 && j == 0) check("t5_level_pushpop", int'(level), 7);
            end
        end
        check("t5_level_end", int'(level), 0);
        check("t5_uflow", int'(underflow), 0);

`ifdef PAM8_PRBS_EN
        // PRBS-9 from 1FF: symbols 111,000,001,111 -> +3,-7,-5,+3
        begin
            int prbs_lev [4] = '{3, -7, -5, 3};
            en = 1'b0;
            do_reset();
            prbs_sel = 1'b1;
            step();
            check("t6_ready", int'(sym_ready), 0);
            step();
            en = 1'b1;
            for (int k = 0; k < 16; k++) begin
                step();
                if (k % 4 == 0)
                    check($sformatf("t6_data%0d", k / 4), int'(data), prbs_lev[k / 4]);
            end
            repeat (1000) step();
            check("t6_uflow", int'(underflow), 0);
            prbs_sel = 1'b0;
            en = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
